// File: rtl/shim_sts_pkg.sv
// Shared definitions for the SPI-status scan controller.
//   - default geometry (N_WORDS / WORD_W)
//   - width of the HOLD stall counter
//   - FSM state encoding
package shim_sts_pkg;
  localparam int DEF_N_WORDS = 16;
  localparam int DEF_WORD_W  = 8;
  localparam int STALL_CNT_W = 16;

  localparam logic [1:0] STS_IDLE  = 2'd0;
  localparam logic [1:0] STS_SCAN  = 2'd1;
  localparam logic [1:0] STS_HOLD  = 2'd2;
  localparam logic [1:0] STS_CLEAR = 2'd3;
endpackage

// File: rtl/shim_spi_sts_scan_ctrl_if.sv
// Handshake bundle of the scan controller.
//   clr_*  : software sticky-clear request (level) and its one-cycle ack
//   evt_*  : valid/ready event stream towards the interrupt/log path
// master : the scan controller (produces events, acknowledges clears)
// slave  : the requester / event consumer
interface shim_spi_sts_scan_ctrl_if #(
  parameter int N_WORDS = shim_sts_pkg::DEF_N_WORDS,
  parameter int WORD_W  = shim_sts_pkg::DEF_WORD_W
);
  import shim_sts_pkg::*;
  localparam int IDX_W = $clog2(N_WORDS);

  logic              clr_req;
  logic [IDX_W-1:0]  clr_idx;
  logic [WORD_W-1:0] clr_mask;
  logic              clr_ack;
  logic              evt_valid;
  logic              evt_ready;
  logic [IDX_W-1:0]  evt_idx;
  logic [WORD_W-1:0] evt_bits;

  modport master (
    output evt_valid, evt_idx, evt_bits, clr_ack,
    input  evt_ready, clr_req, clr_idx, clr_mask
  );
  modport slave (
    input  evt_valid, evt_idx, evt_bits, clr_ack,
    output evt_ready, clr_req, clr_idx, clr_mask
  );
endinterface

// File: rtl/shim_sts_evt_slot.sv
// Single-entry valid/ready output register for event records.
//   aclk, areset : clock, async active-high reset
//   i_load       : capture i_idx/i_bits and raise o_valid (only when slot free)
//   i_ready      : consumer accepts the held record
//   o_valid/o_idx/o_bits : held record, stable while o_valid & !i_ready
module shim_sts_evt_slot
  import shim_sts_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              i_load,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_bits,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [IDX_W-1:0]  o_idx,
  output logic [WORD_W-1:0] o_bits
);
  logic              r_valid;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_bits;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_bits  <= '0;
    end else if (i_load) begin
      // a load in the accept cycle replaces the leaving record
      r_valid <= 1'b1;
      r_idx   <= i_idx;
      r_bits  <= i_bits;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_idx   = r_idx;
  assign o_bits  = r_bits;
endmodule

// File: rtl/shim_spi_sts_scan_ctrl.sv
// Round-robin scanner of stabilized SPI-status words.
// One word per cycle: rising bits set per-word sticky bits and emit one
// event record per changed word; software sticky clears are serialized
// against the scan through a dedicated one-cycle CLEAR state.
//   aclk, areset : clock, async active-high reset
//   sts_in       : N_WORDS x WORD_W status, word i at [i*WORD_W +: WORD_W]
//   sts_valid    : status stable, scanning permitted
//   irq_en       : interrupt enable
//   sticky       : sticky status, same packing as sts_in
//   irq          : registered irq_en & |sticky
//   stall_cnt    : saturating count of cycles spent in HOLD
//   bus          : clear request/ack and event stream (master side)
module shim_spi_sts_scan_ctrl
  import shim_sts_pkg::*;
#(
  parameter int N_WORDS = DEF_N_WORDS,
  parameter int WORD_W  = DEF_WORD_W
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [N_WORDS*WORD_W-1:0] sts_in,
  input  logic                      sts_valid,
  input  logic                      irq_en,
  output logic [N_WORDS*WORD_W-1:0] sticky,
  output logic                      irq,
  output logic [STALL_CNT_W-1:0]    stall_cnt,
  shim_spi_sts_scan_ctrl_if.master  bus
);
  localparam int IDX_W = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  logic [1:0]                     r_state;
  logic [IDX_W-1:0]               r_ptr;
  logic [N_WORDS-1:0][WORD_W-1:0] r_prev;
  logic [N_WORDS-1:0][WORD_W-1:0] r_sticky;
  logic                           r_clr_ack;
  logic                           r_irq;
  logic [STALL_CNT_W-1:0]         r_stall;

  logic [N_WORDS-1:0][WORD_W-1:0] w_sts;
  logic [WORD_W-1:0]              w_cur;
  logic [WORD_W-1:0]              w_rise;
  logic                           w_evt_valid;
  logic                           w_slot_free;
  logic                           w_eval;
  logic                           w_load;
  logic                           w_adv;
  logic                           w_busy;
  logic                           w_clr_hit;

  assign w_sts  = sts_in;
  assign w_cur  = w_sts[r_ptr];
  assign w_rise = w_cur & ~r_prev[r_ptr];

  assign w_slot_free = !w_evt_valid || bus.evt_ready;
  // word p is only evaluated when neither a clear nor a status drop preempts it
  assign w_eval = (r_state == STS_SCAN) && !bus.clr_req && sts_valid;
  assign w_load = w_eval && (w_rise != '0) && w_slot_free;
  assign w_adv  = w_eval && ((w_rise == '0) || w_slot_free);
  assign w_busy = w_eval && (w_rise != '0) && !w_slot_free;
  // out-of-range clear indices are acked but touch nothing
  assign w_clr_hit = (r_state == STS_CLEAR) && (int'(bus.clr_idx) < N_WORDS);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= STS_IDLE;
    end else begin
      case (r_state)
        STS_IDLE: begin
          if (bus.clr_req)    r_state <= STS_CLEAR;
          else if (sts_valid) r_state <= STS_SCAN;
        end
        STS_SCAN: begin
          if (bus.clr_req)     r_state <= STS_CLEAR;
          else if (!sts_valid) r_state <= STS_IDLE;
          else if (w_busy)     r_state <= STS_HOLD;
        end
        STS_HOLD:  if (bus.evt_ready) r_state <= STS_SCAN;
        STS_CLEAR: r_state <= sts_valid ? STS_SCAN : STS_IDLE;
        default:   r_state <= STS_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ptr    <= '0;
      r_prev   <= '0;
      r_sticky <= '0;
    end else begin
      if (w_adv) begin
        r_ptr         <= (r_ptr == LAST_IDX) ? '0 : r_ptr + IDX_W'(1);
        r_prev[r_ptr] <= w_cur;
      end
      // set (SCAN) and clear (CLEAR) live in exclusive states
      if (w_load)
        r_sticky[r_ptr] <= r_sticky[r_ptr] | w_rise;
      else if (w_clr_hit)
        r_sticky[bus.clr_idx] <= r_sticky[bus.clr_idx] & ~bus.clr_mask;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_clr_ack <= 1'b0;
      r_irq     <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_clr_ack <= (r_state == STS_CLEAR);
      r_irq     <= irq_en && (r_sticky != '0);
      if ((r_state == STS_HOLD) && (r_stall != '1))
        r_stall <= r_stall + STALL_CNT_W'(1);
    end
  end

  shim_sts_evt_slot #(.IDX_W(IDX_W), .WORD_W(WORD_W)) u_slot (
    .aclk    (aclk),
    .areset  (areset),
    .i_load  (w_load),
    .i_idx   (r_ptr),
    .i_bits  (w_rise),
    .i_ready (bus.evt_ready),
    .o_valid (w_evt_valid),
    .o_idx   (bus.evt_idx),
    .o_bits  (bus.evt_bits)
  );

  assign bus.evt_valid = w_evt_valid;
  assign bus.clr_ack   = r_clr_ack;
  assign sticky        = r_sticky;
  assign irq           = r_irq;
  assign stall_cnt     = r_stall;
endmodule

// File: tb/tb_shim_spi_sts_scan_ctrl.sv
module tb_shim_spi_sts_scan_ctrl;
  localparam int NW = 16, WW = 8, IW = 4;
  localparam int NW2 = 20;

  logic aclk = 1'b0;
  logic areset;
  logic [NW*WW-1:0]  sts_in, sticky;
  logic              sts_valid, irq_en, irq;
  logic [15:0]       stall_cnt;
  logic [NW2*WW-1:0] sts_in2, sticky2;
  logic              sts_valid2, irq_en2, irq2;
  logic [15:0]       stall_cnt2;

  shim_spi_sts_scan_ctrl_if #(.N_WORDS(NW),  .WORD_W(WW)) bus ();
  shim_spi_sts_scan_ctrl_if #(.N_WORDS(NW2), .WORD_W(WW)) bus2 ();

  shim_spi_sts_scan_ctrl #(.N_WORDS(NW), .WORD_W(WW)) dut (
    .aclk(aclk), .areset(areset), .sts_in(sts_in), .sts_valid(sts_valid),
    .irq_en(irq_en), .sticky(sticky), .irq(irq), .stall_cnt(stall_cnt), .bus(bus));

  shim_spi_sts_scan_ctrl #(.N_WORDS(NW2), .WORD_W(WW)) dut2 (
    .aclk(aclk), .areset(areset), .sts_in(sts_in2), .sts_valid(sts_valid2),
    .irq_en(irq_en2), .sticky(sticky2), .irq(irq2), .stall_cnt(stall_cnt2), .bus(bus2));

  always #5 aclk = ~aclk;

  typedef struct packed { logic [IW-1:0] idx; logic [WW-1:0] bits; } evt_t;
  evt_t mon_q[$];
  int total = 0, bad = 0;

  // reference state: last evaluated value and sticky per word
  logic [WW-1:0] m_prev[NW];
  logic [WW-1:0] m_sticky[NW];

  // every accepted record, captured where valid/ready are stable
  always @(negedge aclk)
    if (!areset && bus.evt_valid && bus.evt_ready)
      mon_q.push_back({bus.evt_idx, bus.evt_bits});

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic set_word(input int w, input logic [WW-1:0] v);
    sts_in[w*WW +: WW] = v;
  endtask

  function automatic logic [WW-1:0] stk(input int w);
    return sticky[w*WW +: WW];
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    bus.clr_req = 1'b0;
    cyc(2);
    areset = 1'b0;
    mon_q.delete();
    for (int w = 0; w < NW; w++) begin m_prev[w] = '0; m_sticky[w] = '0; end
  endtask

  task automatic wait_events(input int n, input int budget, input string name);
    for (int i = 0; i < budget && mon_q.size() < n; i++) cyc();
    if (mon_q.size() < n) begin
      total++; bad++;
      $display("FAIL %s: timeout, events=%0d required=%0d", name, mon_q.size(), n);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    #1;
    total++;
    if ({bus.evt_valid, bus.clr_ack, irq, stall_cnt, bus.evt_idx, bus.evt_bits} !== '0) begin
      bad++; $display("FAIL reset_outs: got v=%b ack=%b irq=%b stall=%0d idx=%0d bits=%h required all 0",
        bus.evt_valid, bus.clr_ack, irq, stall_cnt, bus.evt_idx, bus.evt_bits);
    end
    total++;
    if (sticky !== '0) begin bad++; $display("FAIL reset_sticky: got %h required 0", sticky); end
    cyc(2);
    areset = 1'b0;
  endtask

  task automatic test_single_rise();
    logic [NW*WW-1:0] ev;
    do_reset();
    sts_in = '0; irq_en = 1'b1; bus.evt_ready = 1'b1; sts_valid = 1'b1;
    cyc(40);
    total++;
    if (mon_q.size() != 0) begin bad++; $display("FAIL quiet: events=%0d required 0", mon_q.size()); end
    set_word(3, 8'h04);
    wait_events(1, 40, "single_wait");
    cyc(3);
    total++;
    if (mon_q.size() != 1 || mon_q[0].idx !== 4'd3 || mon_q[0].bits !== 8'h04) begin
      bad++; $display("FAIL single_evt: n=%0d idx=%0d bits=%h required n=1 idx=3 bits=04",
        mon_q.size(), mon_q.size() ? mon_q[0].idx : 4'd0, mon_q.size() ? mon_q[0].bits : 8'd0);
    end
    ev = '0; ev[3*WW +: WW] = 8'h04;
    total++;
    if (sticky !== ev) begin bad++; $display("FAIL single_sticky: got %h required %h", sticky, ev); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL single_irq: got %b required 1", irq); end
  endtask

  task automatic test_rewrap();
    cyc(5*NW);
    total++;
    if (mon_q.size() != 1) begin bad++; $display("FAIL held_high: events=%0d required 1", mon_q.size()); end
    set_word(3, 8'h00);
    cyc(3*NW);
    total++;
    if (mon_q.size() != 1 || stk(3) !== 8'h04) begin
      bad++; $display("FAIL fall: events=%0d sticky3=%h required 1 / 04", mon_q.size(), stk(3));
    end
    set_word(3, 8'h04);
    wait_events(2, 3*NW, "rerise_wait");
    cyc(NW);
    total++;
    if (mon_q.size() != 2 || mon_q[mon_q.size()-1] !== {4'd3, 8'h04}) begin
      bad++; $display("FAIL rerise: events=%0d last=%h required 2 / 304", mon_q.size(), mon_q[mon_q.size()-1]);
    end
  endtask

  task automatic test_clear();
    int acks;
    logic [NW2*WW-1:0] ev2;
    set_word(3, 8'hFF);
    cyc(3*NW);
    total++;
    if (stk(3) !== 8'hFF) begin bad++; $display("FAIL clr_pre: sticky3=%h required ff", stk(3)); end
    bus.clr_idx = 4'd3; bus.clr_mask = 8'h0F; bus.clr_req = 1'b1; acks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.clr_ack) begin acks++; bus.clr_req = 1'b0; break; end
    end
    bus.clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(); if (bus.clr_ack) acks++; end
    total++;
    if (acks != 1) begin bad++; $display("FAIL clr_ack_pulse: acks=%0d required 1", acks); end
    cyc(NW);
    total++;
    if (stk(3) !== 8'hF0) begin bad++; $display("FAIL clr_sticky: sticky3=%h required f0", stk(3)); end

    // out-of-range and last-index clears on the 20-word instance
    total++;
    if (sticky2 !== sts_in2) begin bad++; $display("FAIL clr2_pre: got %h required %h", sticky2, sts_in2); end
    for (int k = 0; k < 2; k++) begin
      bus2.clr_idx = (k == 0) ? 5'd20 : 5'd19; bus2.clr_mask = 8'hFF; bus2.clr_req = 1'b1; acks = 0;
      for (int i = 0; i < 10; i++) begin
        cyc();
        if (bus2.clr_ack) begin acks++; bus2.clr_req = 1'b0; break; end
      end
      bus2.clr_req = 1'b0;
      for (int i = 0; i < 4; i++) begin cyc(); if (bus2.clr_ack) acks++; end
      ev2 = sts_in2;
      if (k == 1) ev2[19*WW +: WW] = 8'h00;
      total++;
      if (acks != 1 || sticky2 !== ev2) begin
        bad++; $display("FAIL clr2_idx%0d: acks=%0d sticky=%h required 1 / %h", bus2.clr_idx, acks, sticky2, ev2);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    sts_in = '0; sts_valid = 1'b0; bus.evt_ready = 1'b0;
    set_word(5, 8'h01); set_word(6, 8'h80);
    sts_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.evt_valid; i++) cyc();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 4'd5 || bus.evt_bits !== 8'h01) begin
        bad++; $display("FAIL hold_stable[%0d]: v=%b idx=%0d bits=%h required 1/5/01",
          i, bus.evt_valid, bus.evt_idx, bus.evt_bits);
      end
      cyc();
    end
    bus.evt_ready = 1'b1;
    cyc();
    total++;
    if (stall_cnt !== 16'd10) begin bad++; $display("FAIL stall_cnt: got %0d required 10", stall_cnt); end
    cyc(3);
    total++;
    if (stall_cnt !== 16'd10 || mon_q.size() != 2 || mon_q[0] !== {4'd5, 8'h01} || mon_q[1] !== {4'd6, 8'h80}) begin
      bad++; $display("FAIL hold_order: stall=%0d n=%0d required 10 / 2 events (5:01, 6:80)", stall_cnt, mon_q.size());
    end
  endtask

  task automatic test_ptr_resume();
    do_reset();
    sts_in = '0; sts_valid = 1'b0; bus.evt_ready = 1'b1;
    cyc(2);
    sts_valid = 1'b1;
    cyc(10);                 // IDLE->SCAN, then words 0..8 evaluated
    sts_valid = 1'b0;
    set_word(8, 8'h01); set_word(9, 8'h02);
    cyc(5);
    total++;
    if (mon_q.size() != 0) begin bad++; $display("FAIL idle_no_scan: events=%0d required 0", mon_q.size()); end
    sts_valid = 1'b1;
    wait_events(2, 60, "resume_wait");
    total++;
    if (mon_q.size() < 2 || mon_q[0].idx !== 4'd9 || mon_q[1].idx !== 4'd8) begin
      bad++; $display("FAIL resume_order: first=%0d second=%0d required 9 then 8",
        mon_q.size() > 0 ? mon_q[0].idx : 4'd0, mon_q.size() > 1 ? mon_q[1].idx : 4'd0);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    sts_in = '0; irq_en = 1'b1; bus.evt_ready = 1'b0;
    set_word(5, 8'h01); set_word(6, 8'h80);
    sts_valid = 1'b1;
    cyc(30);
    areset = 1'b1;
    #1;
    total++;
    if ({bus.evt_valid, bus.clr_ack, irq, stall_cnt, bus.evt_idx, bus.evt_bits} !== '0 || sticky !== '0) begin
      bad++; $display("FAIL reset_hold: v=%b irq=%b stall=%0d idx=%0d sticky=%h required all 0",
        bus.evt_valid, irq, stall_cnt, bus.evt_idx, sticky);
    end
    mon_q.delete();
    cyc(2);
    areset = 1'b0;
    bus.evt_ready = 1'b1;
    wait_events(2, 80, "rerise_after_reset");
    cyc(2*NW);
    total++;
    if (mon_q.size() != 2 || mon_q[0] !== {4'd5, 8'h01} || mon_q[1] !== {4'd6, 8'h80}) begin
      bad++; $display("FAIL reset_rerise: events=%0d required 2 (5:01, 6:80)", mon_q.size());
    end
  endtask

  task automatic test_random();
    logic [WW-1:0] nv, rise;
    logic [WW-1:0] e_bits[NW];
    logic [NW*WW-1:0] ev;
    int n_exp, acks, ci;
    logic [WW-1:0] cm;
    do_reset();
    sts_in = '0; sts_valid = 1'b0;
    for (int r = 0; r < 25; r++) begin
      irq_en = 1'($urandom % 2);
      n_exp = 0;
      for (int w = 0; w < NW; w++) begin
        nv = ($urandom % 2) ? WW'($urandom) : sts_in[w*WW +: WW];
        set_word(w, nv);
        rise = nv & ~m_prev[w];
        e_bits[w] = rise;
        if (rise != '0) n_exp++;
        m_prev[w] = nv;
        m_sticky[w] = m_sticky[w] | rise;
      end
      mon_q.delete();
      sts_valid = 1'b1;
      for (int i = 0; i < 600 && mon_q.size() < n_exp; i++) begin
        bus.evt_ready = 1'($urandom % 2);
        cyc();
      end
      bus.evt_ready = 1'b1;
      cyc(3*NW);
      sts_valid = 1'b0;
      cyc(3);
      total++;
      if (mon_q.size() != n_exp) begin
        bad++; $display("FAIL rnd_count[%0d]: events=%0d required %0d", r, mon_q.size(), n_exp);
      end
      foreach (mon_q[k]) begin
        total++;
        if (mon_q[k].bits == '0 || mon_q[k].bits !== e_bits[mon_q[k].idx]) begin
          bad++; $display("FAIL rnd_evt[%0d]: idx=%0d bits=%h required %h",
            r, mon_q[k].idx, mon_q[k].bits, e_bits[mon_q[k].idx]);
        end
        e_bits[mon_q[k].idx] = '0;   // a second record for the same word now mismatches
      end
      for (int w = 0; w < NW; w++) ev[w*WW +: WW] = m_sticky[w];
      total++;
      if (sticky !== ev) begin bad++; $display("FAIL rnd_sticky[%0d]: got %h required %h", r, sticky, ev); end
      total++;
      if (irq !== (irq_en && ev != '0)) begin
        bad++; $display("FAIL rnd_irq[%0d]: got %b required %b", r, irq, irq_en && ev != '0);
      end
      if ($urandom % 2) begin
        ci = int'($urandom % NW); cm = WW'($urandom);
        bus.clr_idx = IW'(ci); bus.clr_mask = cm; bus.clr_req = 1'b1; acks = 0;
        for (int i = 0; i < 10; i++) begin
          cyc();
          if (bus.clr_ack) begin acks++; bus.clr_req = 1'b0; break; end
        end
        bus.clr_req = 1'b0;
        cyc(2);
        m_sticky[ci] = m_sticky[ci] & ~cm;
        for (int w = 0; w < NW; w++) ev[w*WW +: WW] = m_sticky[w];
        total++;
        if (acks != 1 || sticky !== ev) begin
          bad++; $display("FAIL rnd_clr[%0d]: acks=%0d sticky=%h required 1 / %h", r, acks, sticky, ev);
        end
      end
    end
  endtask

  initial begin
    sts_in = '0; sts_valid = 1'b0; irq_en = 1'b0;
    bus.clr_req = 1'b0; bus.clr_idx = '0; bus.clr_mask = '0; bus.evt_ready = 1'b1;
    for (int w = 0; w < NW2; w++) sts_in2[w*WW +: WW] = WW'(w*37 + 5);
    sts_valid2 = 1'b1; irq_en2 = 1'b0;
    bus2.clr_req = 1'b0; bus2.clr_idx = '0; bus2.clr_mask = '0; bus2.evt_ready = 1'b1;
    test_reset();
    test_single_rise();
    test_rewrap();
    test_clear();
    test_hold();
    test_ptr_resume();
    test_reset_in_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
